// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: control and status bundle for the multi-channel clock divider
interface clk_div_multi_if #(
  parameter int CH = 2,
  parameter int CNT_W = 32
);
  logic [CH-1:0] div_wr;
  logic [CNT_W-1:0] div_data;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] step_req;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] busy;
  modport master (output div_wr, div_data, mode, step_req, input clk_out, tick, busy);
  modport slave (input div_wr, div_data, mode, step_req, output clk_out, tick, busy);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: per-channel programmable divider with run/stop/step modes and tick strobes
module clk_div_multi #(
  parameter int CH = 2,
  parameter int CNT_W = 32,
  parameter int unsigned DEF_DIV = 50000
) (
  input logic CLK_100mhz,
  input logic Reset,
  clk_div_multi_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, STEP_HI, STEP_LO} state_t;
  logic [CH-1:0] clk_v, tick_v, busy_v;
  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, act_n, pend_n;
    logic pend_v, prev, rise, clk_q, clk_n, tick_q, tick_n;
    logic [1:0] md;
    logic run_md, wrap, apply;
    assign md = bus.mode[2*c +: 2];
    assign run_md = md == 2'b01;
    assign wrap = cnt >= act_n;
    // a stopped channel has no phase to protect, so divisor updates land at once
    assign apply = st == IDLE || wrap;
    always_comb begin
      st_n = st;
      cnt_n = wrap ? '0 : cnt + 1'b1;
      clk_n = clk_q ^ wrap;
      case (st)
        IDLE: begin
          cnt_n = '0;
          st_n = run_md ? RUN : (md == 2'b10 && rise) ? STEP_HI : IDLE;
          clk_n = st_n != IDLE;
        end
        RUN: if (!run_md) begin
          st_n = (!clk_q || wrap) ? IDLE : DRAIN;
          if (!clk_q) begin
            cnt_n = '0;
            clk_n = 1'b0;
          end
        end
        DRAIN: st_n = run_md ? RUN : wrap ? IDLE : DRAIN;
        STEP_HI: st_n = wrap ? STEP_LO : STEP_HI;
        STEP_LO: begin
          st_n = wrap ? IDLE : STEP_LO;
          clk_n = 1'b0;
        end
        default: begin
          st_n = IDLE;
          cnt_n = '0;
          clk_n = 1'b0;
        end
      endcase
      tick_n = clk_n & ~clk_q;
    end
    always_ff @(posedge CLK_100mhz or posedge Reset) begin
      if (Reset) begin
        st <= IDLE;
        cnt <= '0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
        act_n <= CNT_W'(DEF_DIV);
        pend_n <= '0;
        pend_v <= 1'b0;
        prev <= 1'b0;
        rise <= 1'b0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
        clk_q <= clk_n;
        tick_q <= tick_n;
        prev <= bus.step_req[c];
        rise <= bus.step_req[c] & ~prev;
        if (apply) begin
          act_n <= bus.div_wr[c] ? bus.div_data : pend_v ? pend_n : act_n;
          pend_v <= 1'b0;
        end else if (bus.div_wr[c]) begin
          pend_n <= bus.div_data;
          pend_v <= 1'b1;
        end
      end
    end
    assign clk_v[c] = clk_q;
    assign tick_v[c] = tick_q;
    assign busy_v[c] = st != IDLE;
  end
  assign bus.clk_out = clk_v;
  assign bus.tick = tick_v;
  assign bus.busy = busy_v;
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed vector table plus hand-built step, reset and concurrency sequences
module tb_clk_div_multi;
  logic CLK_100mhz = 1'b0;
  logic Reset;
  int n_chk = 0;
  int n_err = 0;
  clk_div_multi_if #(.CH(2), .CNT_W(8)) bus ();
  clk_div_multi #(.CH(2), .CNT_W(8), .DEF_DIV(3)) dut (
    .CLK_100mhz(CLK_100mhz),
    .Reset(Reset),
    .bus(bus)
  );
  always #5 CLK_100mhz = ~CLK_100mhz;
  typedef struct {
    logic [1:0] md;
    logic wr;
    logic [7:0] dat;
    logic c;
    logic t;
    logic b;
  } vec_t;
  vec_t vq[$];
  logic [31:0] wc[2], wt[2], wb[2];
  task automatic add(input logic [1:0] md, input logic wr, input logic [7:0] dat,
                     input logic c, input logic t, input logic b, input int reps);
    for (int i = 0; i < reps; i++) vq.push_back('{md, wr, dat, c, t, b});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK_100mhz);
    #1;
  endtask
  task automatic wdiv(input logic [1:0] wr, input logic [7:0] d);
    bus.mode = '0;
    bus.step_req = '0;
    bus.div_wr = wr;
    bus.div_data = d;
    step();
    bus.div_wr = '0;
  endtask
  // bit i of each capture is the output after the i-th edge of the run
  task automatic run(input logic [1:0] m0, input logic [1:0] m1,
                     input logic [31:0] s0, input logic [31:0] s1, input int n);
    for (int k = 0; k < 2; k++) begin
      wc[k] = '0;
      wt[k] = '0;
      wb[k] = '0;
    end
    for (int i = 0; i < n; i++) begin
      bus.mode = {m1, m0};
      bus.step_req = {s1[i], s0[i]};
      step();
      for (int k = 0; k < 2; k++) begin
        wc[k][i] = bus.clk_out[k];
        wt[k][i] = bus.tick[k];
        wb[k][i] = bus.busy[k];
      end
    end
    bus.step_req = '0;
  endtask
  initial begin
    Reset = 1'b1;
    bus.div_wr = '0;
    bus.div_data = '0;
    bus.mode = '0;
    bus.step_req = '0;
    repeat (2) step();
    chk("reset clk_out", 32'(bus.clk_out), 32'h0);
    chk("reset tick", 32'(bus.tick), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    Reset = 1'b0;
    // ch0 with N=3: run, mid-phase write, write on wrap, stop in high/low phase, drain return
    add(2'b00, 0, 0, 0, 0, 0, 1);
    add(2'b01, 0, 0, 1, 1, 1, 1);
    add(2'b01, 0, 0, 1, 0, 1, 3);
    add(2'b01, 0, 0, 0, 0, 1, 4);
    add(2'b01, 0, 0, 1, 1, 1, 1);
    add(2'b01, 1, 1, 1, 0, 1, 1);
    add(2'b01, 0, 0, 1, 0, 1, 2);
    add(2'b01, 0, 0, 0, 0, 1, 2);
    add(2'b01, 0, 0, 1, 1, 1, 1);
    add(2'b01, 0, 0, 1, 0, 1, 1);
    add(2'b01, 0, 0, 0, 0, 1, 2);
    add(2'b01, 0, 0, 1, 1, 1, 1);
    add(2'b01, 0, 0, 1, 0, 1, 1);
    add(2'b01, 1, 3, 0, 0, 1, 1);
    add(2'b01, 0, 0, 0, 0, 1, 3);
    add(2'b01, 0, 0, 1, 1, 1, 1);
    add(2'b01, 0, 0, 1, 0, 1, 1);
    add(2'b00, 0, 0, 1, 0, 1, 2);
    add(2'b00, 0, 0, 0, 0, 0, 2);
    add(2'b01, 0, 0, 1, 1, 1, 1);
    add(2'b01, 0, 0, 1, 0, 1, 3);
    add(2'b01, 0, 0, 0, 0, 1, 1);
    add(2'b00, 0, 0, 0, 0, 0, 2);
    add(2'b01, 0, 0, 1, 1, 1, 1);
    add(2'b00, 0, 0, 1, 0, 1, 1);
    add(2'b01, 0, 0, 1, 0, 1, 2);
    add(2'b01, 0, 0, 0, 0, 1, 1);
    add(2'b11, 0, 0, 0, 0, 0, 1);
    foreach (vq[i]) begin
      bus.mode = {2'b00, vq[i].md};
      bus.div_wr = {1'b0, vq[i].wr};
      bus.div_data = vq[i].dat;
      step();
      chk($sformatf("vec%0d clk_out", i), 32'(bus.clk_out[0]), 32'(vq[i].c));
      chk($sformatf("vec%0d tick", i), 32'(bus.tick[0]), 32'(vq[i].t));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy[0]), 32'(vq[i].b));
    end
    bus.div_wr = '0;
    chk("table ch1 idle", 32'({bus.clk_out[1], bus.busy[1]}), 32'h0);
    // single step N=2 with extra requests during the high and low phases
    wdiv(2'b01, 8'd2);
    run(2'b10, 2'b00, 32'h49, 32'h0, 12);
    chk("step clk_out", wc[0], 32'h00E);
    chk("step tick", wt[0], 32'h002);
    chk("step busy", wb[0], 32'h07E);
    run(2'b10, 2'b00, 32'hFFFF, 32'h0, 16);
    chk("held step clk_out", wc[0], 32'h000E);
    chk("held step tick", wt[0], 32'h0002);
    chk("held step busy", wb[0], 32'h007E);
    // N=0 toggles every cycle, then async reset mid-period
    wdiv(2'b01, 8'd0);
    run(2'b01, 2'b00, 32'h0, 32'h0, 8);
    chk("n0 clk_out", wc[0], 32'h55);
    chk("n0 tick", wt[0], 32'h55);
    chk("n0 busy", wb[0], 32'hFF);
    bus.mode = 4'b0001;
    step();
    chk("pre-reset clk_out", 32'(bus.clk_out[0]), 32'h1);
    #2 Reset = 1'b1;
    #1;
    chk("async reset clk_out", 32'(bus.clk_out), 32'h0);
    chk("async reset tick", 32'(bus.tick), 32'h0);
    chk("async reset busy", 32'(bus.busy), 32'h0);
    repeat (2) step();
    Reset = 1'b0;
    run(2'b01, 2'b00, 32'h0, 32'h0, 16);
    chk("post-reset clk_out", wc[0], 32'h0F0F);
    chk("post-reset tick", wt[0], 32'h0101);
    chk("post-reset busy", wb[0], 32'hFFFF);
    // stop in the low phase while loading ch1 with N=5
    wdiv(2'b10, 8'd5);
    chk("low-phase stop busy", 32'(bus.busy), 32'h0);
    run(2'b01, 2'b10, 32'h0, 32'h1, 20);
    chk("conc ch0 clk_out", wc[0], 32'hF0F0F);
    chk("conc ch0 tick", wt[0], 32'h10101);
    chk("conc ch0 busy", wb[0], 32'hFFFFF);
    chk("conc ch1 clk_out", wc[1], 32'h0007E);
    chk("conc ch1 tick", wt[1], 32'h00002);
    chk("conc ch1 busy", wb[1], 32'h01FFE);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
